// File: rtl/gpio_pad_pkg.sv
// Shared definitions for the GPIO pad controller: config word layout,
// reset config value, FSM state codes and the register-port request bundle.
package gpio_pad_pkg;

  localparam int CFG_W  = 13;
  localparam int ADDR_W = 4;

  // Bit offsets inside a pad config word
  localparam int B_OEB      = 0;
  localparam int B_INP_DIS  = 1;
  localparam int B_IB_MODE  = 2;
  localparam int B_VTRIP    = 3;
  localparam int B_SLOW     = 4;
  localparam int B_HOLDOVER = 5;
  localparam int B_AN_EN    = 6;
  localparam int B_AN_SEL   = 7;
  localparam int B_AN_POL   = 8;
  localparam int B_DM_LO    = 9;
  localparam int B_HOLD     = 12;

  // Safe state: output driver off, weak drive mode, nothing analog, no hold
  localparam logic [CFG_W-1:0] CFG_DEFAULT = 13'h0201;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [CFG_W-1:0]  wdata;
  } cfg_req_t;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int num_io);
    return int'(addr) >= num_io;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// One-bit pad input synchroniser with rise/fall detection on the
// synchronised level.
module gpio_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO padframe controller: power-up enable sequencing, per-pad config
// registers behind a valid/ready port, pad control fan-out and input sampling.
module gpio_pad_ctrl import gpio_pad_pkg::*; #(
  parameter int NUM_IO      = 16,
  parameter int CFG_W       = 13,
  parameter int SYNC_STAGES = 2,
  parameter int ENH_DELAY   = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic                cfg_write_i,
  input  logic [3:0]          cfg_addr_i,
  input  logic [CFG_W-1:0]    cfg_wdata_i,
  output logic [CFG_W-1:0]    cfg_rdata_o,
  output logic                cfg_rvalid_o,
  output logic                cfg_err_o,
  input  logic [NUM_IO-1:0]   gpio_out_i,
  output logic [NUM_IO-1:0]   gpio_in_o,
  output logic [NUM_IO-1:0]   gpio_rise_o,
  output logic [NUM_IO-1:0]   gpio_fall_o,
  input  logic [NUM_IO-1:0]   io_in_i,
  output logic [NUM_IO-1:0]   io_out_o,
  output logic [NUM_IO-1:0]   oeb_o,
  output logic [NUM_IO-1:0]   inp_dis_o,
  output logic [NUM_IO-1:0]   ib_mode_sel_o,
  output logic [NUM_IO-1:0]   vtrip_sel_o,
  output logic [NUM_IO-1:0]   slow_sel_o,
  output logic [NUM_IO-1:0]   holdover_o,
  output logic [NUM_IO-1:0]   analog_en_o,
  output logic [NUM_IO-1:0]   analog_sel_o,
  output logic [NUM_IO-1:0]   analog_pol_o,
  output logic [NUM_IO-1:0]   hldh_n_o,
  output logic [NUM_IO-1:0]   enh_o,
  output logic [3*NUM_IO-1:0] dm_o
);

  localparam int CNT_W = $clog2(ENH_DELAY) + 1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      if (cnt_q == CNT_W'(ENH_DELAY - 1)) state_d = S_RUN;
      else                                cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run         = (state_q == S_RUN);
  assign cfg_ready_o = run;

  // Register port
  cfg_req_t req;
  logic     accept, bad, rd_acc;

  assign req    = '{write: cfg_write_i, addr: cfg_addr_i, wdata: cfg_wdata_i};
  assign accept = cfg_valid_i & run;
  assign bad    = addr_bad(req.addr, NUM_IO);
  assign rd_acc = accept & ~req.write;

  logic [NUM_IO-1:0][CFG_W-1:0] cfg_q;
  logic [CFG_W-1:0]             rd_sel;
  logic [CFG_W-1:0]             rdata_q, rdata_d;
  logic                         rvalid_q, err_q;
  logic [NUM_IO-1:0]            io_out_q;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_IO; i++)
      if (req.addr == ADDR_W'(i)) rd_sel = cfg_q[i];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = bad ? '0 : rd_sel;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_IO; i++) cfg_q[i] <= CFG_DEFAULT;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      io_out_q <= '0;
    end else begin
      // Out-of-range writes match no pad and are dropped
      for (int i = 0; i < NUM_IO; i++)
        if (accept && req.write && req.addr == ADDR_W'(i)) cfg_q[i] <= req.wdata;
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
      err_q    <= accept & bad;
      io_out_q <= gpio_out_i;
    end
  end

  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;

  // Pad fan-out: until the enable sequence completes every pad sees the safe default
  logic [NUM_IO-1:0][CFG_W-1:0] pad_cfg;

  always_comb begin
    for (int i = 0; i < NUM_IO; i++) pad_cfg[i] = run ? cfg_q[i] : CFG_DEFAULT;
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    assign oeb_o[i]         = pad_cfg[i][B_OEB];
    assign inp_dis_o[i]     = pad_cfg[i][B_INP_DIS];
    assign ib_mode_sel_o[i] = pad_cfg[i][B_IB_MODE];
    assign vtrip_sel_o[i]   = pad_cfg[i][B_VTRIP];
    assign slow_sel_o[i]    = pad_cfg[i][B_SLOW];
    assign holdover_o[i]    = pad_cfg[i][B_HOLDOVER];
    assign analog_en_o[i]   = pad_cfg[i][B_AN_EN];
    assign analog_sel_o[i]  = pad_cfg[i][B_AN_SEL];
    assign analog_pol_o[i]  = pad_cfg[i][B_AN_POL];
    assign dm_o[3*i +: 3]   = pad_cfg[i][B_DM_LO +: 3];
    assign hldh_n_o[i]      = ~(run & pad_cfg[i][B_HOLD]);
  end

  assign enh_o    = {NUM_IO{run}};
  assign io_out_o = run ? io_out_q : '0;

  gpio_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_IO-1:0] (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .async_i (io_in_i),
    .level_o (gpio_in_o),
    .rise_o  (gpio_rise_o),
    .fall_o  (gpio_fall_o)
  );

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed sequences and a response table, plus
// randomized traffic checked every cycle against a behavioural model.
module tb_gpio_pad_ctrl;

  localparam int NIO = 12;
  localparam int CW  = 13;
  localparam int ENH = 8;
  localparam logic [CW-1:0] DEF = 13'h0201;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, cfg_write, cfg_rvalid, cfg_err;
  logic [3:0] cfg_addr;
  logic [CW-1:0] cfg_wdata, cfg_rdata;
  logic [NIO-1:0] gpio_out, gpio_in, gpio_rise, gpio_fall, io_in, io_out;
  logic [NIO-1:0] oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover;
  logic [NIO-1:0] analog_en, analog_sel, analog_pol, hldh_n, enh;
  logic [3*NIO-1:0] dm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.NUM_IO(NIO), .CFG_W(CW), .SYNC_STAGES(2), .ENH_DELAY(ENH)) dut (
    .clock_i(clk), .reset_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_write_i(cfg_write),
    .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
    .cfg_rvalid_o(cfg_rvalid), .cfg_err_o(cfg_err),
    .gpio_out_i(gpio_out), .gpio_in_o(gpio_in), .gpio_rise_o(gpio_rise), .gpio_fall_o(gpio_fall),
    .io_in_i(io_in), .io_out_o(io_out), .oeb_o(oeb), .inp_dis_o(inp_dis),
    .ib_mode_sel_o(ib_mode_sel), .vtrip_sel_o(vtrip_sel), .slow_sel_o(slow_sel),
    .holdover_o(holdover), .analog_en_o(analog_en), .analog_sel_o(analog_sel),
    .analog_pol_o(analog_pol), .hldh_n_o(hldh_n), .enh_o(enh), .dm_o(dm)
  );

  // Behavioural model state
  logic [CW-1:0]  cfg_m [NIO];
  logic [CW-1:0]  rdata_m;
  logic           rvalid_m, err_m;
  logic [NIO-1:0] io_out_m;
  logic [NIO-1:0] samp [3];   // io_in as seen at the last three edges, newest first
  int             cyc;        // edges since reset, saturating at ENH

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    int a;
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < NIO; i++) cfg_m[i] = DEF;
      rdata_m = '0; rvalid_m = 1'b0; err_m = 1'b0; io_out_m = '0;
      for (int k = 0; k < 3; k++) samp[k] = '0;
    end else begin
      a = int'(cfg_addr);
      acc = cfg_valid && (cyc >= ENH);
      rvalid_m = acc && !cfg_write;
      err_m = acc && (a >= NIO);
      if (acc && !cfg_write) rdata_m = (a < NIO) ? cfg_m[a] : '0;
      if (acc && cfg_write && a < NIO) cfg_m[a] = cfg_wdata;
      io_out_m = gpio_out;
      samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = io_in;
      if (cyc < ENH) cyc++;
    end
  endtask

  task automatic check_all();
    bit run;
    logic [CW-1:0] w;
    logic [NIO-1:0] e_oeb, e_ind, e_ib, e_vt, e_sl, e_ho, e_ae, e_as, e_ap, e_hl;
    logic [3*NIO-1:0] e_dm;
    run = (cyc >= ENH);
    for (int i = 0; i < NIO; i++) begin
      w = run ? cfg_m[i] : DEF;
      e_oeb[i] = w[0]; e_ind[i] = w[1]; e_ib[i] = w[2]; e_vt[i] = w[3];
      e_sl[i] = w[4]; e_ho[i] = w[5]; e_ae[i] = w[6]; e_as[i] = w[7]; e_ap[i] = w[8];
      e_dm[3*i +: 3] = w[11:9];
      e_hl[i] = run ? ~w[12] : 1'b1;
    end
    chk("cfg_ready", cfg_ready, run);
    chk("cfg_rvalid", cfg_rvalid, rvalid_m);
    chk("cfg_err", cfg_err, err_m);
    chk("cfg_rdata", cfg_rdata, rdata_m);
    chk("enh", enh, run ? {NIO{1'b1}} : '0);
    chk("io_out", io_out, run ? io_out_m : '0);
    chk("gpio_in", gpio_in, samp[1]);
    chk("gpio_rise", gpio_rise, samp[1] & ~samp[2]);
    chk("gpio_fall", gpio_fall, ~samp[1] & samp[2]);
    chk("oeb", oeb, e_oeb);
    chk("inp_dis", inp_dis, e_ind);
    chk("ib_mode_sel", ib_mode_sel, e_ib);
    chk("vtrip_sel", vtrip_sel, e_vt);
    chk("slow_sel", slow_sel, e_sl);
    chk("holdover", holdover, e_ho);
    chk("analog_en", analog_en, e_ae);
    chk("analog_sel", analog_sel, e_as);
    chk("analog_pol", analog_pol, e_ap);
    chk("dm", dm, e_dm);
    chk("hldh_n", hldh_n, e_hl);
  endtask

  logic [NIO-1:0] go_v, ii_v;

  task automatic cycle(input bit r, input bit v, input bit wr, input logic [3:0] a,
                       input logic [CW-1:0] d);
    rst = r; cfg_valid = v; cfg_write = wr; cfg_addr = a; cfg_wdata = d;
    gpio_out = go_v; io_in = ii_v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 4'd0, '0);
  endtask

  typedef struct {
    bit            wr;
    logic [3:0]    addr;
    logic [CW-1:0] wdata;
    bit            rv;
    bit            err;
    logic [CW-1:0] rdata;
  } vec_t;

  vec_t tbl[8];
  int rise_cnt, fall_cnt, rise_t, fall_t, gin_t;

  initial begin
    tbl[0] = '{1'b0, 4'd3,  13'h0000, 1'b1, 1'b0, 13'h0C00};
    tbl[1] = '{1'b0, 4'd15, 13'h0000, 1'b1, 1'b1, 13'h0000};
    tbl[2] = '{1'b1, 4'd12, 13'h1FFF, 1'b0, 1'b1, 13'h0000};
    tbl[3] = '{1'b0, 4'd12, 13'h0000, 1'b1, 1'b1, 13'h0000};
    tbl[4] = '{1'b1, 4'd11, 13'h0155, 1'b0, 1'b0, 13'h0000};
    tbl[5] = '{1'b0, 4'd11, 13'h0000, 1'b1, 1'b0, 13'h0155};
    tbl[6] = '{1'b0, 4'd2,  13'h0000, 1'b1, 1'b0, 13'h00AA};
    tbl[7] = '{1'b0, 4'd4,  13'h0000, 1'b1, 1'b0, 13'h0201};

    go_v = '0; ii_v = '0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    gpio_out = '0; io_in = '0;

    // Reset and the power-up enable sequence
    cycle(1'b1, 1'b0, 1'b0, 4'd0, '0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk("rst_enh", enh, '0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_oeb", oeb, 12'hFFF);
    chk("rst_hldh_n", hldh_n, 12'hFFF);
    chk("rst_rvalid", cfg_rvalid, 1'b0);
    // A write held from S_INIT must only land once ready rises
    for (int n = 1; n <= ENH; n++) begin
      cycle(1'b0, 1'b1, 1'b1, 4'd2, 13'h00AA);
      if (n < ENH) begin
        chk("init_enh", enh, '0);
        chk("init_oeb", oeb, 12'hFFF);
      end else begin
        chk("run_enh", enh, 12'hFFF);
        chk("run_ready", cfg_ready, 1'b1);
        chk("run_dm0", dm[2:0], 3'b001);
        chk("run_oeb_pre", oeb, 12'hFFF);
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 4'd2, 13'h00AA);
    chk("held_wr_oeb2", oeb[2], 1'b0);
    chk("held_wr_inp_dis2", inp_dis[2], 1'b1);
    chk("held_wr_dm2", dm[8:6], 3'b000);

    // Write pad 3 with its output driven high
    go_v = 12'h008;
    cycle(1'b0, 1'b1, 1'b1, 4'd3, 13'h0C00);
    chk("wr3_oeb3", oeb[3], 1'b0);
    chk("wr3_dm3", dm[11:9], 3'b110);
    chk("wr3_io_out3", io_out[3], 1'b1);
    idle();

    // Response table
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, tbl[k].wr, tbl[k].addr, tbl[k].wdata);
      chk($sformatf("tbl%0d_rvalid", k), cfg_rvalid, tbl[k].rv);
      chk($sformatf("tbl%0d_err", k), cfg_err, tbl[k].err);
      if (tbl[k].rv) chk($sformatf("tbl%0d_rdata", k), cfg_rdata, tbl[k].rdata);
      idle();
      chk($sformatf("tbl%0d_rvalid_drop", k), cfg_rvalid, 1'b0);
      chk($sformatf("tbl%0d_err_drop", k), cfg_err, 1'b0);
      if (tbl[k].rv) chk($sformatf("tbl%0d_rdata_hold", k), cfg_rdata, tbl[k].rdata);
    end

    // Hold on pad 0, then reconfigure while held
    cycle(1'b0, 1'b1, 1'b1, 4'd0, 13'h1201);
    chk("hold_hldh_n0", hldh_n[0], 1'b0);
    chk("hold_oeb0", oeb[0], 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 4'd0, 13'h1000);
    chk("hold_upd_oeb0", oeb[0], 1'b0);
    chk("hold_upd_hldh_n0", hldh_n[0], 1'b0);
    idle();

    // io_in[5] pulse six cycles wide
    rise_cnt = 0; fall_cnt = 0; rise_t = -1; fall_t = -1; gin_t = -1;
    for (int t = 0; t < 14; t++) begin
      ii_v[5] = (t < 6);
      idle();
      if (gpio_rise[5]) begin rise_cnt++; rise_t = t; end
      if (gpio_fall[5]) begin fall_cnt++; fall_t = t; end
      if (gpio_in[5] && gin_t < 0) gin_t = t;
    end
    chk("io5_gin_lat", gin_t, 1);
    chk("io5_rise_cnt", rise_cnt, 1);
    chk("io5_fall_cnt", fall_cnt, 1);
    chk("io5_rise_t", rise_t, 1);
    chk("io5_fall_t", fall_t, 7);

    // Reset landing on the same edge as a read
    cycle(1'b1, 1'b1, 1'b0, 4'd0, '0);
    chk("midrst_rvalid", cfg_rvalid, 1'b0);
    chk("midrst_hldh_n", hldh_n, 12'hFFF);
    chk("midrst_enh", enh, '0);
    chk("midrst_ready", cfg_ready, 1'b0);
    for (int n = 1; n <= ENH; n++) idle();
    chk("midrst_enh_back", enh, 12'hFFF);
    chk("midrst_oeb0", oeb[0], 1'b1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      go_v = NIO'($urandom);
      ii_v = NIO'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            4'($urandom), CW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
